// File: rtl/ste_energy_win_pkg.sv
// Shared types and helpers for the short-time-energy estimator.
// Width helpers keep the squarer and accumulator sized together.
package ste_pkg;

  typedef enum logic {ST_FILL, ST_RUN} ste_state_e;

  function automatic int sq_w(input int in_w);
    return 2 * in_w - 1;
  endfunction

  function automatic int sum_w(input int in_w, input int win_log2);
    return sq_w(in_w) + win_log2;
  endfunction

  function automatic logic [31:0] sat_u(
    input logic [31:0] val,
    input int          w
  );
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/ste_energy_win_if.sv
// Sample-in / level-out bundle of the energy estimator.
// slave is the estimator side, master the producer/consumer side.
interface ste_energy_win_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
);
  logic                   clr_i;
  logic signed [IN_W-1:0] sample_i;
  logic                   sample_valid_i;
  logic [OUT_W-1:0]       ste_o;
  logic                   ste_update_o;
  logic                   clr_o;
  logic                   win_full_o;

  modport master (
    output clr_i, sample_i, sample_valid_i,
    input  ste_o, ste_update_o, clr_o, win_full_o
  );

  modport slave (
    input  clr_i, sample_i, sample_valid_i,
    output ste_o, ste_update_o, clr_o, win_full_o
  );
endinterface

// File: rtl/ste_energy_win_sq_buf.sv
// Circular store of the last WIN_LEN squared samples.
// Each write returns the entry it overwrites, one clock later.
module ste_sq_buf #(
  parameter int SQ_W     = 15,
  parameter int WIN_LOG2 = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_we,
  input  logic [SQ_W-1:0] i_wdata,
  output logic [SQ_W-1:0] o_old
);
  localparam int WIN_LEN = 1 << WIN_LOG2;

  logic [SQ_W-1:0]     r_buf [WIN_LEN];
  logic [WIN_LOG2-1:0] r_ptr;
  logic [SQ_W-1:0]     r_old;

  assign o_old = r_old;

  // read-before-write of the oldest slot, pointer wraps mod WIN_LEN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_LEN; i++) r_buf[i] <= '0;
      r_ptr <= '0;
      r_old <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < WIN_LEN; i++) r_buf[i] <= '0;
      r_ptr <= '0;
      r_old <= '0;
    end else if (i_we) begin
      r_old        <= r_buf[r_ptr];
      r_buf[r_ptr] <= i_wdata;
      r_ptr        <= r_ptr + WIN_LOG2'(1);
    end
  end
endmodule

// File: rtl/ste_energy_win.sv
// Sliding-window energy: square, running sum, scaled mean level.
// Three-stage pipeline, one sample per clock, fixed latency 3.
module ste_energy_win
  import ste_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int WIN_LOG2  = 4,
  parameter int OUT_W     = 4,
  parameter int OUT_SHIFT = 2 * IN_W - 2 - OUT_W,
  parameter int UPD_DIV   = 1
) (
  input logic             clk,
  input logic             rst_n,
  ste_energy_win_if.slave bus
);
  localparam int SQ_W    = sq_w(IN_W);
  localparam int SUM_W   = sum_w(IN_W, WIN_LOG2);
  localparam int WIN_LEN = 1 << WIN_LOG2;
  localparam int DEC_W   = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;

  ste_state_e          r_state;
  ste_state_e          w_state_nxt;
  logic [WIN_LOG2-1:0] r_fill;
  logic [DEC_W-1:0]    r_dec;

  logic                   w_clr;
  logic                   w_acc;
  logic signed [IN_W-1:0] w_smp;
  logic [SQ_W-1:0]        w_sq;
  logic [SQ_W-1:0]        w_old;
  logic                   w_last_fill;
  logic                   w_run_smp;
  logic                   w_upd;
  logic [SUM_W-1:0]       w_mean;

  logic [SQ_W-1:0]  r_sq;
  logic             r_v1;
  logic             r_u1;
  logic [SUM_W-1:0] r_sum;
  logic             r_u2;
  logic [OUT_W-1:0] r_ste;
  logic             r_upd;
  logic             r_clr;

  assign w_clr = bus.clr_i;
  assign w_acc = bus.sample_valid_i & ~w_clr;
  assign w_smp = bus.sample_i;
  assign w_sq  = SQ_W'(w_smp * w_smp);

  assign w_last_fill = (r_state == ST_FILL) &&
                       (r_fill == WIN_LOG2'(WIN_LEN - 1));
  assign w_run_smp   = w_acc &&
                       ((r_state == ST_RUN) || w_last_fill);
  assign w_upd       = w_run_smp && (r_dec == '0);
  assign w_mean      = r_sum >> WIN_LOG2;

  assign bus.ste_o        = r_ste;
  assign bus.ste_update_o = r_upd;
  assign bus.clr_o        = r_clr;
  assign bus.win_full_o   = (r_state == ST_RUN);

  ste_sq_buf #(
    .SQ_W     (SQ_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_we    (w_acc),
    .i_wdata (w_sq),
    .o_old   (w_old)
  );

  // window state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FILL;
    else        r_state <= w_state_nxt;
  end

  // enter RUN on the sample that completes the window
  always_comb begin
    w_state_nxt = r_state;
    if (w_clr)                    w_state_nxt = ST_FILL;
    else if (w_acc && w_last_fill) w_state_nxt = ST_RUN;
  end

  // fill count during FILL, update decimation during RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
      r_dec  <= '0;
    end else if (w_clr) begin
      r_fill <= '0;
      r_dec  <= '0;
    end else begin
      if (w_acc && (r_state == ST_FILL))
        r_fill <= r_fill + WIN_LOG2'(1);
      if (w_run_smp)
        r_dec <= (r_dec == DEC_W'(UPD_DIV - 1)) ?
                 '0 : r_dec + DEC_W'(1);
    end
  end

  // stage 1: capture the new square alongside its update flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sq <= '0;
      r_v1 <= 1'b0;
      r_u1 <= 1'b0;
    end else if (w_clr) begin
      r_sq <= '0;
      r_v1 <= 1'b0;
      r_u1 <= 1'b0;
    end else begin
      r_v1 <= w_acc;
      r_u1 <= w_upd;
      if (w_acc) r_sq <= w_sq;
    end
  end

  // stage 2: add newest square, drop the one it displaced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_u2  <= 1'b0;
    end else if (w_clr) begin
      r_sum <= '0;
      r_u2  <= 1'b0;
    end else begin
      r_u2 <= r_v1 & r_u1;
      if (r_v1)
        r_sum <= r_sum + SUM_W'(r_sq) - SUM_W'(w_old);
    end
  end

  // stage 3: scale, saturate and publish the level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ste <= '0;
      r_upd <= 1'b0;
      r_clr <= 1'b0;
    end else begin
      r_clr <= w_clr;
      if (w_clr) begin
        r_ste <= '0;
        r_upd <= 1'b0;
      end else begin
        r_upd <= r_u2;
        if (r_u2)
          r_ste <= OUT_W'(sat_u(32'(w_mean >> OUT_SHIFT), OUT_W));
      end
    end
  end
endmodule
